ram_responder: RTL and testbench

- Synthesizable memory responder: the memory side of the CPU↔RAM bus that the test benches drive.
- Holds separate instruction and data banks, each with registered read/write and explicit acknowledges.
- Has a post-reset clear sweep, so the core sees a deterministic all-zero memory.
- Sits between the control unit/fetch stage and storage, replacing the behavioural RAM model in system builds.

---
 rtl/ram_responder_pkg.sv | 14 +
 rtl/ram_responder_bank.sv | 62 ++++++
 rtl/ram_responder.sv | 116 +++++++++++
 tb/tb_ram_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_responder_pkg.sv
// Shared widths and FSM encoding for the CPU<->RAM memory responder.
package ram_responder_pkg;

    localparam int unsigned ADDR_WIDTH   = 8;
    localparam int unsigned DATA_WIDTH   = 21;
    localparam int unsigned INST_WIDTH   = 21;
    localparam int unsigned NUM_MEM_ADDR = 1 << ADDR_WIDTH;

    typedef enum logic {
        RS_CLEAR = 1'b0,
        RS_READY = 1'b1
    } rs_state_t;

endpackage

// File: rtl/ram_responder_bank.sv
// Single-port write-first memory bank with registered read data and ack.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_clr_we/i_clr_addr : sweep write of zero (takes the write port)
//   i_rd, i_wr          : request strobes, i_addr / i_din request payload
//   o_dout              : registered read data, held when no read
//   o_ack               : one-cycle pulse the cycle after any request
module ram_bank #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned AW    = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr_we,
    input  logic [AW-1:0]    i_clr_addr,
    input  logic             i_rd,
    input  logic             i_wr,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_ack
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] r_dout;
    logic             r_ack;

    // Sweep writes and request writes share one port; the top never overlaps them.
    always_comb begin
        w_we    = i_clr_we | i_wr;
        w_waddr = i_clr_we ? i_clr_addr : i_addr;
        w_wdata = i_clr_we ? '0 : i_din;
    end

    // Storage array (not reset; the sweep provides the deterministic contents).
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Write-first read port and acknowledge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dout <= '0;
            r_ack  <= 1'b0;
        end else begin
            r_ack <= i_rd | i_wr;
            if (i_rd) begin
                r_dout <= i_wr ? i_din : r_mem[i_addr];
            end
        end
    end

    assign o_dout = r_dout;
    assign o_ack  = r_ack;

endmodule

// File: rtl/ram_responder.sv
// Memory responder: independent data and instruction banks, optional
// post-reset zero sweep during which Ram_Busy is high and requests are ignored.
//   Clk, Reset                      : clock, synchronous active-high reset
//   Ram_Data_Read/Write, Ram_Addr   : data-bank request, Ram_Data_In write data
//   Ram_Inst_Read/Write, Inst_Addr  : instruction-bank request, Ram_Inst_In write data
//   Ram_Data_Out / Ram_Inst_Out     : registered read data
//   Ram_Data_Ack / Ram_Inst_Ack     : per-request completion pulses
//   Ram_Busy                        : high while sweeping
module ram_responder
    import ram_responder_pkg::rs_state_t;
    import ram_responder_pkg::RS_CLEAR;
    import ram_responder_pkg::RS_READY;
#(
    parameter int unsigned ADDR_WIDTH     = ram_responder_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = ram_responder_pkg::DATA_WIDTH,
    parameter int unsigned INST_WIDTH     = ram_responder_pkg::INST_WIDTH,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Ram_Data_Read,
    input  logic                  Ram_Data_Write,
    input  logic                  Ram_Inst_Read,
    input  logic                  Ram_Inst_Write,
    input  logic [ADDR_WIDTH-1:0] Ram_Addr,
    input  logic [ADDR_WIDTH-1:0] Inst_Addr,
    input  logic [DATA_WIDTH-1:0] Ram_Data_In,
    input  logic [INST_WIDTH-1:0] Ram_Inst_In,
    output logic [DATA_WIDTH-1:0] Ram_Data_Out,
    output logic [INST_WIDTH-1:0] Ram_Inst_Out,
    output logic                  Ram_Data_Ack,
    output logic                  Ram_Inst_Ack,
    output logic                  Ram_Busy
);

    rs_state_t             r_state;
    rs_state_t             w_next_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_next;
    logic                  r_busy;
    logic                  w_clr_we;
    logic                  w_req_en;

    // State, sweep counter and busy flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= CLEAR_ON_RESET ? RS_CLEAR : RS_READY;
            r_cnt   <= '0;
            r_busy  <= CLEAR_ON_RESET;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_busy  <= (w_next_state == RS_CLEAR);
        end
    end

    // Next state: sweep one entry per cycle, leave CLEAR after the last entry.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_clr_we     = 1'b0;
        case (r_state)
            RS_CLEAR: begin
                w_clr_we   = 1'b1;
                w_cnt_next = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == '1) begin
                    w_next_state = RS_READY;
                end
            end
            RS_READY: begin
                w_next_state = RS_READY;
            end
            default: begin
                w_next_state = RS_READY;
            end
        endcase
    end

    // Requests reach the banks only when serviceable.
    assign w_req_en = (r_state == RS_READY) && !Reset;

    ram_bank #(
        .WIDTH (DATA_WIDTH),
        .AW    (ADDR_WIDTH)
    ) u_data_bank (
        .i_clk      (Clk),
        .i_reset    (Reset),
        .i_clr_we   (w_clr_we),
        .i_clr_addr (r_cnt),
        .i_rd       (Ram_Data_Read & w_req_en),
        .i_wr       (Ram_Data_Write & w_req_en),
        .i_addr     (Ram_Addr),
        .i_din      (Ram_Data_In),
        .o_dout     (Ram_Data_Out),
        .o_ack      (Ram_Data_Ack)
    );

    ram_bank #(
        .WIDTH (INST_WIDTH),
        .AW    (ADDR_WIDTH)
    ) u_inst_bank (
        .i_clk      (Clk),
        .i_reset    (Reset),
        .i_clr_we   (w_clr_we),
        .i_clr_addr (r_cnt),
        .i_rd       (Ram_Inst_Read & w_req_en),
        .i_wr       (Ram_Inst_Write & w_req_en),
        .i_addr     (Inst_Addr),
        .i_din      (Ram_Inst_In),
        .o_dout     (Ram_Inst_Out),
        .o_ack      (Ram_Inst_Ack)
    );

    assign Ram_Busy = r_busy;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: driver updates a plain-array memory
// model and queues expected acks/data; a negedge monitor pops and compares.
module tb_ram_responder;

    logic        clk;
    logic        reset;
    logic        d_rd, d_wr, i_rd, i_wr;
    logic [7:0]  d_addr, i_addr;
    logic [20:0] d_in, i_in;
    logic [20:0] d_out, i_out;
    logic        d_ack, i_ack, busy;

    ram_responder dut (
        .Clk            (clk),
        .Reset          (reset),
        .Ram_Data_Read  (d_rd),
        .Ram_Data_Write (d_wr),
        .Ram_Inst_Read  (i_rd),
        .Ram_Inst_Write (i_wr),
        .Ram_Addr       (d_addr),
        .Inst_Addr      (i_addr),
        .Ram_Data_In    (d_in),
        .Ram_Inst_In    (i_in),
        .Ram_Data_Out   (d_out),
        .Ram_Inst_Out   (i_out),
        .Ram_Data_Ack   (d_ack),
        .Ram_Inst_Ack   (i_ack),
        .Ram_Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          rd;
        logic [20:0] d;
    } exp_t;

    exp_t        qd[$];
    exp_t        qi[$];
    logic [20:0] mdata [256];
    logic [20:0] minst [256];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    bit          rst_q  = 1'b1;
    logic [20:0] last_d = '0;
    logic [20:0] last_i = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, req);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Monitor: an ack must appear exactly on the cycle its request is due.
    always @(negedge clk) begin
        if (rst_q) begin
            last_d = '0;
            last_i = '0;
        end
        if (mon_on) begin
            if (qd.size() > 0 && qd[0].due == cyc) begin
                exp_t e;
                e = qd.pop_front();
                chk("data_ack", 32'(d_ack), 32'd1);
                if (e.rd) last_d = e.d;
            end else begin
                chk("data_ack_idle", 32'(d_ack), 32'd0);
            end
            chk("data_out", 32'(d_out), 32'(last_d));
            if (qi.size() > 0 && qi[0].due == cyc) begin
                exp_t e;
                e = qi.pop_front();
                chk("inst_ack", 32'(i_ack), 32'd1);
                if (e.rd) last_i = e.d;
            end else begin
                chk("inst_ack_idle", 32'(i_ack), 32'd0);
            end
            chk("inst_out", 32'(i_out), 32'(last_i));
        end
    end

    // One request cycle on both banks; model is write-first.
    task automatic drive(input bit dr, input bit dw, input logic [7:0] da, input logic [20:0] dd,
                         input bit ir, input bit iw, input logic [7:0] ia, input logic [20:0] id);
        d_rd = dr; d_wr = dw; d_addr = da; d_in = dd;
        i_rd = ir; i_wr = iw; i_addr = ia; i_in = id;
        if (dw) mdata[da] = dd;
        if (iw) minst[ia] = id;
        if (dr || dw) qd.push_back('{due: cyc + 1, rd: dr, d: mdata[da]});
        if (ir || iw) qi.push_back('{due: cyc + 1, rd: ir, d: minst[ia]});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 8'h0, 21'h0, 0, 0, 8'h0, 21'h0);
    endtask

    task automatic do_reset();
        idle(2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 256; k++) begin
            mdata[k] = '0;
            minst[k] = '0;
        end
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_data_out", 32'(d_out), 32'd0);
        chk("reset_inst_out", 32'(i_out), 32'd0);
        chk("reset_acks", 32'({d_ack, i_ack}), 32'd0);
    endtask

    // Counts post-edge samples with Ram_Busy high, bounded.
    task automatic count_busy(input int want);
        int n;
        n = 0;
        while (n < 1000) begin
            if (busy !== 1'b1) break;
            n++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", 32'(n), 32'(want));
    endtask

    initial begin
        reset = 1'b1;
        d_rd = 0; d_wr = 0; i_rd = 0; i_wr = 0;
        d_addr = '0; i_addr = '0; d_in = '0; i_in = '0;
        @(posedge clk); #1;
        mon_on = 1'b1;

        do_reset();
        count_busy(256);

        // Cleared memory reads zero.
        drive(1, 0, 8'h7F, 21'h0, 1, 0, 8'h7F, 21'h0);
        // Write then read back next cycle.
        drive(0, 1, 8'h05, 21'h1ABCD, 0, 0, 8'h0, 21'h0);
        drive(1, 0, 8'h05, 21'h0, 0, 0, 8'h0, 21'h0);
        // Same address, both banks, same cycle.
        drive(0, 1, 8'h10, 21'h00123, 0, 1, 8'h10, 21'h0F0F0);
        drive(1, 0, 8'h10, 21'h0, 1, 0, 8'h10, 21'h0);
        // Read+write same cycle returns the new value.
        drive(0, 1, 8'h20, 21'h00007, 0, 0, 8'h0, 21'h0);
        drive(1, 1, 8'h20, 21'h15555, 0, 0, 8'h0, 21'h0);
        idle(1);
        drive(1, 0, 8'h20, 21'h0, 0, 0, 8'h0, 21'h0);
        // Held read across three addresses.
        drive(0, 1, 8'h01, 21'h0000A, 0, 0, 8'h0, 21'h0);
        drive(0, 1, 8'h02, 21'h0000B, 0, 0, 8'h0, 21'h0);
        drive(0, 1, 8'h03, 21'h0000C, 0, 0, 8'h0, 21'h0);
        drive(1, 0, 8'h01, 21'h0, 0, 0, 8'h0, 21'h0);
        drive(1, 0, 8'h02, 21'h0, 0, 0, 8'h0, 21'h0);
        drive(1, 0, 8'h03, 21'h0, 0, 0, 8'h0, 21'h0);
        idle(2);
        // Boundary addresses.
        drive(0, 1, 8'hFF, 21'h1FFFFF, 0, 1, 8'h00, 21'h1FFFFF);
        drive(1, 0, 8'hFF, 21'h0, 1, 0, 8'h00, 21'h0);

        // Randomised traffic over a narrow address window to force collisions.
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 21'($urandom),
                  1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 21'($urandom));
        end
        idle(2);

        // Reset partway through a sweep restarts the full sweep.
        drive(0, 1, 8'h03, 21'h1FFFF, 0, 0, 8'h0, 21'h0);
        drive(1, 0, 8'h03, 21'h0, 0, 0, 8'h0, 21'h0);
        do_reset();
        for (int k = 0; k < 98; k++) begin
            @(posedge clk); #1;
        end
        do_reset();
        count_busy(256);
        drive(1, 0, 8'h03, 21'h0, 1, 0, 8'h03, 21'h0);

        for (int k = 0; k < 100; k++) begin
            drive(1'($urandom), 1'($urandom), 8'($urandom), 21'($urandom),
                  1'($urandom), 1'($urandom), 8'($urandom), 21'($urandom));
        end
        idle(3);
        chk("queues_drained", 32'(qd.size() + qi.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
